chip_6502_bus_seq: RTL and testbench

//  Bus sequencer for the netlist-level chip_6502 core. Generates the 6502 phase clock (phi) from clk,

---
 rtl/chip_6502_bus_pkg.sv | 23 ++
 rtl/chip_6502_res_gen.sv | 36 +++
 rtl/chip_6502_bus_seq.sv | 140 ++++++++++++++
 tb/tb_chip_6502_bus_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_6502_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chip_6502_bus_pkg
// Purpose  : Shared types for the chip_6502 bus sequencer (state encoding and
//            phase-counter width helper).
// Revision : 1.0 - initial release
// ============================================================================
package chip_6502_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PH1      = 2'd1,
        PH2      = 2'd2,
        PH2_WAIT = 2'd3
    } bus_state_t;

    // Width of the half-phase counter; never narrower than one bit.
    function automatic int cnt_w(input int half_cycles);
        return (half_cycles > 2) ? $clog2(half_cycles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chip_6502_res_gen.sv
`default_nettype none
// ============================================================================
// Module   : chip_6502_res_gen
// Purpose  : Holds the core reset low for RES_CYCLES phi cycles after res
//            releases, counting phi-fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module chip_6502_res_gen #(
    parameter int RES_CYCLES = 8
) (
    input  logic clk,
    input  logic res,
    input  logic strobe,
    output logic cpu_res
);

    localparam int CW = $clog2(RES_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!res) begin
            cnt     <= CW'(RES_CYCLES);
            cpu_res <= 1'b0;
        end else if (strobe && !cpu_res) begin
            if (cnt <= CW'(1)) begin
                cpu_res <= 1'b1;
            end
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/chip_6502_bus_seq.sv
`default_nettype none
// ============================================================================
// Module   : chip_6502_bus_seq
// Purpose  : Phi generator and req/ack memory sequencer for chip_6502.
//            Optional single-step input enabled by CHIP_6502_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module chip_6502_bus_seq
    import chip_6502_bus_pkg::*;
#(
    parameter int HALF_CYCLES = 8,
    parameter int RES_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        res,
    input  logic        run,
`ifdef CHIP_6502_STEP_EN
    input  logic        step,
`endif
    output logic        phi,
    output logic        cpu_res,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_dbo,
    output logic [7:0]  cpu_dbi,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        cycle_done
);

    localparam int               CNT_W    = cnt_w(HALF_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_WR   = CNT_W'(HALF_CYCLES - 2);

    bus_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             start;
    logic             xfer_ok;
    logic             complete;
    logic             wr_next;

`ifdef CHIP_6502_STEP_EN
    assign start = run | step;
`else
    assign start = run;
`endif
    assign xfer_ok  = mem_req & mem_ack;
    assign complete = done | xfer_ok;
    assign wr_next  = ~cpu_rw & cpu_res;

    always_ff @(posedge clk) begin
        if (!res) begin
            state      <= IDLE;
            cnt        <= '0;
            done       <= 1'b0;
            phi        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_dbi    <= '0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (xfer_ok) begin
                mem_req <= 1'b0;
                done    <= 1'b1;
                if (!mem_we) begin
                    cpu_dbi <= mem_rdata;
                end
            end
            case (state)
                IDLE: begin
                    phi <= 1'b0;
                    cnt <= '0;
                    if (start) begin
                        state <= PH1;
                    end
                end
                PH1: begin
                    if (cnt == CNT_LAST) begin
                        // Reads go out with the phi rise; writes wait for late-phi2 data.
                        mem_addr <= cpu_ab;
                        mem_we   <= wr_next;
                        mem_req  <= ~wr_next;
                        done     <= 1'b0;
                        phi      <= 1'b1;
                        cnt      <= '0;
                        state    <= PH2;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PH2: begin
                    if (mem_we && cnt == CNT_WR) begin
                        mem_req   <= 1'b1;
                        mem_wdata <= cpu_dbo;
                    end
                    if (cnt == CNT_LAST) begin
                        if (complete) begin
                            phi        <= 1'b0;
                            cycle_done <= 1'b1;
                            cnt        <= '0;
                            state      <= run ? PH1 : IDLE;
                        end else begin
                            state <= PH2_WAIT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PH2_WAIT: begin
                    if (xfer_ok) begin
                        phi        <= 1'b0;
                        cycle_done <= 1'b1;
                        cnt        <= '0;
                        state      <= run ? PH1 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    chip_6502_res_gen #(
        .RES_CYCLES (RES_CYCLES)
    ) u_res_gen (
        .clk     (clk),
        .res     (res),
        .strobe  (cycle_done),
        .cpu_res (cpu_res)
    );

endmodule
`default_nettype wire

// File: tb/tb_chip_6502_bus_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_chip_6502_bus_seq
// Purpose  : Scoreboard bench for chip_6502_bus_seq (HALF_CYCLES=4, RES_CYCLES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chip_6502_bus_seq;

    localparam int H = 4;
    localparam int R = 2;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          high;
    } txn_t;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        phi, cpu_res, mem_req, mem_we, cycle_done;
    logic [15:0] cpu_ab = '0;
    logic        cpu_rw = 1'b1;
    logic [7:0]  cpu_dbo = '0;
    logic [7:0]  cpu_dbi, mem_wdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int   checks = 0;
    int   errors = 0;
    txn_t exp_q[$];
    int   cyc_idx = 0;
    int   cur_delay = 0;
    int   age = 0;
    logic run_s = 1'b0;
    logic alive = 1'b1;

    chip_6502_bus_seq #(.HALF_CYCLES(H), .RES_CYCLES(R)) dut (
        .clk        (clk),
        .res        (res),
        .run        (run),
`ifdef CHIP_6502_STEP_EN
        .step       (step),
`endif
        .phi        (phi),
        .cpu_res    (cpu_res),
        .cpu_ab     (cpu_ab),
        .cpu_rw     (cpu_rw),
        .cpu_dbo    (cpu_dbo),
        .cpu_dbi    (cpu_dbi),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Memory model: acks once the request has been pending cur_delay clocks.
    always @(posedge clk) begin
        #1;
        if (mem_req === 1'b1) begin
            mem_ack = (age >= cur_delay);
            age++;
        end else begin
            mem_ack = 1'b0;
            age = 0;
        end
    end

    always @(posedge clk) run_s <= run;

    // Monitor: compares every transaction and every bus cycle against the queue.
    int   hi = 0, lo = 0, falls = 0, nx = 0;
    logic prev_phi = 1'b0, b2b = 1'b0, dbi_chk = 1'b0;
    logic [7:0] dbi_model = '0;
    always @(negedge clk) begin
        txn_t t;
        if (!res) begin
            hi = 0; lo = 0; falls = 0; nx = 0;
            prev_phi = 1'b0; b2b = 1'b0; dbi_chk = 1'b0; dbi_model = '0;
        end else begin
            if (dbi_chk) begin
                chk("cpu_dbi_read", 32'(cpu_dbi), 32'(dbi_model));
                dbi_chk = 1'b0;
            end
            if (phi && !prev_phi) begin
                if (b2b) chk("phi_low_len", 32'(lo), 32'(H));
                chk("cpu_res_at_rise", 32'(cpu_res), 32'(falls >= R));
            end
            if (mem_req && mem_ack) begin
                nx++;
                if (exp_q.size() == 0) begin
                    chk("xfer_expected", 32'(0), 32'(1));
                end else begin
                    t = exp_q[0];
                    chk("mem_we", 32'(mem_we), 32'(t.we));
                    chk("mem_addr", 32'(mem_addr), 32'(t.addr));
                    chk("xfer_phi_high", 32'(phi), 32'(1));
                    if (t.we) begin
                        chk("mem_wdata", 32'(mem_wdata), 32'(t.wdata));
                    end else begin
                        dbi_model = t.rdata;
                        dbi_chk = 1'b1;
                    end
                end
            end
            if (cycle_done) begin
                if (exp_q.size() == 0) begin
                    chk("cycle_expected", 32'(0), 32'(1));
                end else begin
                    t = exp_q.pop_front();
                    chk("phi_high_len", 32'(hi), 32'(t.high));
                end
                chk("xfers_per_cycle", 32'(nx), 32'(1));
                chk("phi_fell", 32'(phi), 32'(0));
                chk("cpu_dbi_hold", 32'(cpu_dbi), 32'(dbi_model));
                nx = 0;
                falls++;
                b2b = run_s;
            end
            if (phi) begin
                if (!prev_phi) hi = 0;
                hi++;
            end else begin
                if (prev_phi) lo = 0;
                lo++;
            end
            prev_phi = phi;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Sets the CPU side for the next bus cycle and records what it must produce.
    // mode: 0 random, 1 read wait 10, 2 read F000/A9, 3 write 5A, 4 read wait 20
    task automatic issue(input int mode);
        txn_t t;
        logic rw;
        int   d;
        t.addr  = 16'($urandom);
        rw      = 1'($urandom);
        t.wdata = 8'($urandom);
        t.rdata = 8'($urandom);
        d       = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
        case (mode)
            1: begin rw = 1'b1; d = 10; end
            2: begin rw = 1'b1; d = 0; t.addr = 16'hF000; t.rdata = 8'hA9; end
            3: begin rw = 1'b0; d = 0; t.wdata = 8'h5A; end
            4: begin rw = 1'b1; d = 20; end
            default: ;
        endcase
        t.we   = !rw && (cyc_idx >= R);
        t.high = t.we ? (H + d) : ((d + 1 > H) ? d + 1 : H);
        cpu_ab    = t.addr;
        cpu_rw    = rw;
        cpu_dbo   = t.wdata;
        mem_rdata = t.rdata;
        cur_delay = d;
        exp_q.push_back(t);
        cyc_idx++;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        if (!alive) return;
        while (cycle_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            chk(name, 32'(0), 32'(1));
            alive = 1'b0;
        end
    endtask

    task automatic wait_phi_high(input string name);
        int n = 0;
        if (!alive) return;
        while (phi !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            chk(name, 32'(0), 32'(1));
            alive = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, 32'({phi, cpu_res, mem_req, mem_we, cycle_done}), 32'(0));
        chk({name, "_data"}, 32'({mem_addr, mem_wdata, cpu_dbi}), 32'(0));
    endtask

    initial begin
        repeat (3) tick();
        check_reset_outputs("reset_state");

        exp_q.delete();
        cyc_idx = 0;
        issue(0);
        run = 1'b1;
        res = 1'b1;

        // Free-running cycles with directed read, write and wait-state cycles mixed in.
        for (int i = 0; i < 30 && alive; i++) begin
            wait_done("timeout_run");
            tick();
            issue(i == 2 ? 2 : i == 3 ? 3 : i == 4 ? 1 : 0);
        end

        // Stop mid-phi2: the cycle still finishes, then phi parks low.
        wait_phi_high("timeout_phi_rise");
        run = 1'b0;
        wait_done("timeout_stop");
        tick();
        issue(0);
        for (int i = 0; i < 20 && alive; i++) begin
            tick();
            chk("idle_parked", 32'({phi, cycle_done}), 32'(0));
        end
        run = 1'b1;
        for (int i = 0; i < 6 && alive; i++) begin
            wait_done("timeout_resume");
            tick();
            issue(0);
        end

`ifdef CHIP_6502_STEP_EN
        run = 1'b0;
        wait_done("timeout_step_stop");
        tick();
        issue(0);
        repeat (5) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_done("timeout_step");
        tick();
        issue(0);
        for (int i = 0; i < 30 && alive; i++) begin
            tick();
            chk("step_single", 32'({phi, cycle_done}), 32'(0));
        end
        run = 1'b1;
`endif

        // Reset in the middle of a stretched read.
        wait_done("timeout_pre_reset");
        tick();
        issue(4);
        wait_phi_high("timeout_wait_rise");
        repeat (H + 2) tick();
        chk("wait_req_held", 32'({phi, mem_req}), 32'(3));
        res = 1'b0;
        tick();
        check_reset_outputs("reset_mid_xfer");
        exp_q.delete();
        cyc_idx = 0;
        issue(0);
        res = 1'b1;
        for (int i = 0; i < 8 && alive; i++) begin
            wait_done("timeout_after_reset");
            tick();
            issue(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
